// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// State encodings double as the LED pattern on the board.
package alu_cmd_sequencer_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Operand/result bus between the sequencer and the combinational ALU.
// The sequencer drives operands; the ALU answers combinationally.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_res;
    logic             alu_car;
    logic             alu_of;

    modport master (
        output alu_a, alu_b, alu_ctrl,
        input  alu_res, alu_car, alu_of
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl,
        output alu_res, alu_car, alu_of
    );
endinterface

// File: rtl/alu_cmd_sequencer_btn_debounce.sv
// Two-flop synchroniser, stable-high counter and rising-edge pulse
// for the raw step button.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] TOP  = CW'(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level;

    // Synchronise, count stable-high cycles, pulse once when level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (!sync2) begin
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                if (cnt != TOP) begin
                    cnt <= cnt + 1'b1;
                end
                if (cnt == LAST) begin
                    level <= 1'b1;
                    press <= ~level;
                end
            end
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Operand/op-code collector for the board ALU: one press per field,
// one-cycle execute, registered result for the display stage.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     sw,
    input  logic                 btn,
    alu_cmd_sequencer_if.master  alu,
    output logic [WIDTH-1:0]     res_q,
    output logic                 car_q,
    output logic                 of_q,
    output logic                 res_valid,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     op_cnt
);
    state_t           st;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic             press;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    assign alu.alu_a    = a_q;
    assign alu.alu_b    = b_q;
    assign alu.alu_ctrl = ctrl_q;
    assign state        = st;

    // Step through the fields on each press; capture ALU output in S_EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
            op_cnt    <= '0;
        end else begin
            res_valid <= 1'b0;
            case (st)
                S_A: begin
                    if (press) begin
                        a_q <= sw;
                        st  <= S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        b_q <= sw;
                        st  <= S_OP;
                    end
                end
                S_OP: begin
                    if (press) begin
                        ctrl_q <= sw[2:0];
                        st     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q     <= alu.alu_res;
                    car_q     <= alu.alu_car;
                    of_q      <= alu.alu_of;
                    op_cnt    <= op_cnt + CNT_W'(1);
                    res_valid <= 1'b1;
                    st        <= S_SHOW;
                end
                S_SHOW: begin
                    if (press) begin
                        st <= S_A;
                    end
                end
                default: begin
                    st <= S_A;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU
// and a result scoreboard.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int W  = 4;
    localparam int DB = 4;
    localparam int CW = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] res;
        logic         car;
        logic         of;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         car;
        logic         of;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn;
    logic [W-1:0]  sw;
    logic [W-1:0]  res_q;
    logic          car_q;
    logic          of_q;
    logic          res_valid;
    logic [2:0]    state;
    logic [CW-1:0] op_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_op = 0;
    int n_press = 0;
    int n_valid = 0;
    logic [CW-1:0] exp_cnt = '0;
    exp_t sbq[$];

    alu_cmd_sequencer_if #(.WIDTH(W)) alu_bus ();

    alu_cmd_sequencer #(
        .WIDTH     (W),
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn       (btn),
        .alu       (alu_bus),
        .res_q     (res_q),
        .car_q     (car_q),
        .of_q      (of_q),
        .res_valid (res_valid),
        .state     (state),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural 4-bit ALU; carry on SUB means "no borrow".
    logic [W:0]   sum;
    logic [W-1:0] r;
    always_comb begin
        sum = '0;
        r   = '0;
        alu_bus.alu_car = 1'b0;
        alu_bus.alu_of  = 1'b0;
        case (alu_bus.alu_ctrl)
            OP_ADD: begin
                sum = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};
                r = sum[W-1:0];
                alu_bus.alu_car = sum[W];
                alu_bus.alu_of = (alu_bus.alu_a[W-1] == alu_bus.alu_b[W-1])
                              && (r[W-1] != alu_bus.alu_a[W-1]);
            end
            OP_SUB: begin
                sum = {1'b0, alu_bus.alu_a} + {1'b0, ~alu_bus.alu_b} + 1'b1;
                r = sum[W-1:0];
                alu_bus.alu_car = sum[W];
                alu_bus.alu_of = (alu_bus.alu_a[W-1] != alu_bus.alu_b[W-1])
                              && (r[W-1] != alu_bus.alu_a[W-1]);
            end
            OP_NOT: r = ~alu_bus.alu_a;
            OP_AND: r = alu_bus.alu_a & alu_bus.alu_b;
            OP_OR:  r = alu_bus.alu_a | alu_bus.alu_b;
            OP_XOR: r = alu_bus.alu_a ^ alu_bus.alu_b;
            OP_LT:  r = (alu_bus.alu_a < alu_bus.alu_b) ? W'(1) : W'(0);
            OP_EQ:  r = (alu_bus.alu_a == alu_bus.alu_b) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        alu_bus.alu_res = r;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Press pulses are observed to measure latency and count bounces.
    always @(negedge clk) begin
        if (dut.u_db.press) begin
            n_press++;
            if (state == 3'(S_OP)) t_op = cyc;
        end
    end

    // Scoreboard: pop one expectation per res_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_cnt = '0;
        end else if (res_valid) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_empty: res_valid with no expected result");
            end else begin
                e = sbq.pop_front();
                exp_cnt = exp_cnt + 1'b1;
                chk("res_q", 32'(res_q), 32'(e.res));
                chk("car_q", 32'(car_q), 32'(e.car));
                chk("of_q", 32'(of_q), 32'(e.of));
                chk("latency", 32'(cyc - t_op), 32'd2);
                chk("op_cnt", 32'(op_cnt), 32'(exp_cnt));
                n_valid++;
            end
        end
    end

    task automatic do_press(input logic [W-1:0] v);
        sw  = v;
        btn = 1'b1;
        repeat (DB + 6) @(negedge clk);
        btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input exp_t e);
        sbq.push_back(e);
        do_press(a);
        do_press(b);
        do_press({1'b0, op});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[10];

    initial begin
        int p0;
        int v0;
        bit got;
        vt[0] = '{4'h3, 4'h5, OP_ADD, 4'h8, 1'b0, 1'b1};
        vt[1] = '{4'h7, 4'h1, OP_SUB, 4'h6, 1'b1, 1'b0};
        vt[2] = '{4'hA, 4'h3, OP_AND, 4'h2, 1'b0, 1'b0};
        vt[3] = '{4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0};
        vt[4] = '{4'h8, 4'h1, OP_SUB, 4'h7, 1'b1, 1'b1};
        vt[5] = '{4'h5, 4'h3, OP_XOR, 4'h6, 1'b0, 1'b0};
        vt[6] = '{4'hC, 4'h0, OP_NOT, 4'h3, 1'b0, 1'b0};
        vt[7] = '{4'h6, 4'h6, OP_EQ,  4'h1, 1'b0, 1'b0};
        vt[8] = '{4'h9, 4'h4, OP_OR,  4'hD, 1'b0, 1'b0};
        vt[9] = '{4'h2, 4'h9, OP_LT,  4'h1, 1'b0, 1'b0};

        rst = 1'b1;
        btn = 1'b0;
        sw  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_bus.alu_b), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_bus.alu_ctrl), 32'd0);
        chk("rst_res_q", 32'(res_q), 32'd0);
        chk("rst_car_of", 32'({car_q, of_q}), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_op_cnt", 32'(op_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].op,
                   '{vt[i].res, vt[i].car, vt[i].of});
            chk("vec_alu_a", 32'(alu_bus.alu_a), 32'(vt[i].a));
            chk("vec_alu_b", 32'(alu_bus.alu_b), 32'(vt[i].b));
            chk("vec_alu_ctrl", 32'(alu_bus.alu_ctrl), 32'(vt[i].op));
            chk("vec_state_show", 32'(state), 32'(S_SHOW));
            do_press(4'h0);
            chk("vec_state_back", 32'(state), 32'(S_A));
            chk("vec_res_hold", 32'(res_q), 32'(vt[i].res));
        end
        chk("vec_valid_count", 32'(n_valid), 32'd10);
        chk("vec_op_cnt", 32'(op_cnt), 32'd10);

        sw = 4'h9;
        p0 = n_press;
        for (int g = 1; g <= 3; g++) begin
            btn = 1'b1;
            repeat (g) @(negedge clk);
            btn = 1'b0;
            repeat (6) @(negedge clk);
        end
        chk("glitch_no_press", 32'(n_press - p0), 32'd0);
        btn = 1'b1;
        repeat (20) @(negedge clk);
        btn = 1'b0;
        repeat (6) @(negedge clk);
        chk("bounce_one_press", 32'(n_press - p0), 32'd1);
        chk("bounce_state", 32'(state), 32'(S_B));

        do_press(4'h2);
        chk("mid_state_op", 32'(state), 32'(S_OP));
        chk("mid_alu_a", 32'(alu_bus.alu_a), 32'h9);
        chk("mid_alu_b", 32'(alu_bus.alu_b), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_alu_a", 32'(alu_bus.alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_bus.alu_b), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_op_cnt", 32'(op_cnt), 32'd0);
        chk("mid_rst_res_q", 32'(res_q), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_press(4'h4);
        chk("pre_race_state", 32'(state), 32'(S_B));
        sw  = 4'h5;
        btn = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (dut.u_db.press) got = 1'b1;
        end
        chk("race_press_seen", 32'(got), 32'd1);
        rst = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        chk("race_state", 32'(state), 32'd0);
        chk("race_alu_b", 32'(alu_bus.alu_b), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("race_state_after", 32'(state), 32'd0);

        v0 = n_valid;
        for (int i = 0; i < 256; i++) begin
            run_op(4'h1, 4'h1, OP_ADD, '{4'h2, 1'b0, 1'b0});
            if (i == 254) chk("wrap_pre", 32'(op_cnt), 32'd255);
            do_press(4'h0);
        end
        chk("wrap_valid_count", 32'(n_valid - v0), 32'd256);
        chk("wrap_op_cnt", 32'(op_cnt), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        chk("force_pre_state", 32'(state), 32'(S_A));
        dut.st = state_t'(3'd6);
        #1;
        chk("force_state6", 32'(state), 32'd6);
        @(negedge clk);
        chk("force_recover", 32'(state), 32'd0);
        chk("force_alu_a_hold", 32'(alu_bus.alu_a), 32'h1);
        chk("force_op_cnt_hold", 32'(op_cnt), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream operand/command stage for the 4-bit board ALU.
- Collects operand A, operand B and the 3-bit op code from board switches, one per debounced button press.
- Presents them to the combinational ALU and registers the ALU's res/car/of for the display stage.
- Counts completed operations.

Parameters:
- WIDTH, 4, operand and result width.
- DB_CYCLES, 4, consecutive stable-high cycles needed to accept a press. Simulation default; the board build overrides it.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sw  input  WIDTH  switch data (operand value, or op code in sw[2:0])
- btn  input  1  raw step button, asynchronous to clk, may bounce
- alu_a  output  WIDTH  registered operand A to ALU
- alu_b  output  WIDTH  registered operand B to ALU
- alu_ctrl  output  3  registered op code to ALU
- alu_res  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_car  input  1  ALU carry
- alu_of  input  1  ALU overflow
- res_q  output  WIDTH  captured result
- car_q  output  1  captured carry
- of_q  output  1  captured overflow
- res_valid  output  1  one-cycle pulse when res_q/car_q/of_q update
- state  output  3  current FSM state encoding, for LEDs
- op_cnt  output  CNT_W  completed operations, wraps

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state = S_A; debouncer cleared.

Input synchronisation and debounce:
- btn passes through a 2-flop synchroniser, then the debouncer.
- A counter increments while the synchronised btn is 1 and clears to 0 when it is 0.
- The debounced level rises when the counter reaches DB_CYCLES and falls when the synchronised btn is 0.
- press = one-cycle pulse on the rising edge of the debounced level. Holding btn yields exactly one press.
- Glitches shorter than DB_CYCLES produce no press.

FSM (encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4):
- S_A: on press, alu_a <= sw; go to S_B.
- S_B: on press, alu_b <= sw; go to S_OP.
- S_OP: on press, alu_ctrl <= sw[2:0]; go to S_EXEC.
- S_EXEC: lasts exactly one cycle and ignores press. At the end of the cycle, capture res_q <= alu_res, car_q <= alu_car, of_q <= alu_of, and op_cnt <= op_cnt+1. Go to S_SHOW.
- res_valid is high for the single cycle after S_EXEC, i.e. the first cycle of S_SHOW.
- S_SHOW: on press, go to S_A. alu_a, alu_b, alu_ctrl and the captured outputs hold until overwritten.
- Unused encodings 5-7 go to S_A on the next cycle with no register update.

Timing and boundary rules:
- Latency: press pulse in S_OP at cycle t → S_EXEC at t+1 → res_q valid and res_valid=1 at t+2.
- alu_a, alu_b and alu_ctrl change only in their load states. They are stable for the whole of S_EXEC.
- op_cnt wraps 2^CNT_W-1 → 0 with no flag.
- rst wins over press in the same cycle.
- rst mid-sequence (any state) discards partial operands: all registers return to 0 and state = S_A.
- No unintended latches: every register has an explicit reset and explicit hold.

Decomposition:
- Shared package: state encodings S_A..S_SHOW, op-code constants OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_LT=6, OP_EQ=7, and WIDTH default.
- Sub-module: btn_debounce (synchroniser + counter + edge pulse, parameter DB_CYCLES, ports clk/rst/btn/press).
- The FSM and capture registers stay in alu_cmd_sequencer.

Test Plan:
- rst=1 for 2 cycles, then release → all outputs 0, state=0, res_valid=0.
- Bench ALU model. Press with sw=3, then sw=5, then sw=000 (ADD) → alu_a=3, alu_b=5, alu_ctrl=0; res_q=8, car_q=0, of_q=1; res_valid one cycle, exactly 2 cycles after the third press pulse; op_cnt=1.
- sw=4'h7, 4'h1, op=001 (SUB) → res_q=6, car_q=1, of_q=0. Then press in S_SHOW → state=0; res_q stays 6.
- btn bounce: 1-cycle, 2-cycle and 3-cycle high glitches, then held high 20 cycles → exactly one press; state advances by one only.
- Assert rst while in S_OP with alu_a=9, alu_b=2 → next cycle alu_a=0, alu_b=0, state=0, op_cnt=0; rst with simultaneous press still yields state=0.
- Run 256 complete operations → op_cnt wraps to 0 on the 256th res_valid; force state=6 via hierarchical deposit → state=0 next cycle.
